// File: rtl/conv_mac_accum.sv
// Convolution multiply-accumulate stage: sums KSIZE pixel*weight products per window
// and hands each window result downstream over a valid/ready handshake.
module conv_mac_accum #(
    parameter int KSIZE = 9,
    parameter int ACC_W = 20,
    parameter bit RELU  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [15:0]      n_windows,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       pixel,
    input  logic [7:0]       weight,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic             busy,
    output logic             done
);

    localparam int TAP_W = (KSIZE > 1) ? $clog2(KSIZE) : 1;

    typedef enum logic [1:0] {
        IDLE,
        ACCUM,
        HOLD
    } state_t;

    state_t state, state_nxt;

    logic signed [ACC_W-1:0] acc;
    logic [TAP_W-1:0]        tap_cnt;
    logic [15:0]             win_cnt;

    logic                    beat;
    logic                    last_tap;
    logic                    out_fire;
    logic signed [16:0]      product;
    logic signed [ACC_W-1:0] product_ext;
    logic signed [ACC_W-1:0] window_sum;
    logic [ACC_W-1:0]        result;

    assign in_ready = (state == ACCUM);
    assign busy     = (state != IDLE);
    assign beat     = in_valid && in_ready;
    assign last_tap = (tap_cnt == TAP_W'(KSIZE - 1));
    assign out_fire = out_valid && out_ready;

    // Pixel is unsigned, so a zero MSB is prepended before the signed multiply.
    assign product     = 17'($signed({1'b0, pixel})) * 17'($signed(weight));
    assign product_ext = ACC_W'(product);
    assign window_sum  = acc + product_ext;
    assign result      = (RELU && window_sum[ACC_W-1]) ? '0 : window_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (start && (n_windows != 16'd0)) begin
                    state_nxt = ACCUM;
                end
            end
            ACCUM: begin
                if (beat && last_tap) begin
                    state_nxt = HOLD;
                end
            end
            HOLD: begin
                if (out_fire) begin
                    state_nxt = (win_cnt != 16'd0) ? ACCUM : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // win_cnt is decremented as each window closes, so it reads zero in HOLD of the final window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc       <= '0;
            tap_cnt   <= '0;
            win_cnt   <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
            done      <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (n_windows != 16'd0) begin
                            acc     <= '0;
                            tap_cnt <= '0;
                            win_cnt <= n_windows;
                        end else begin
                            done <= 1'b1;
                        end
                    end
                end
                ACCUM: begin
                    if (beat) begin
                        if (last_tap) begin
                            out_data  <= result;
                            out_valid <= 1'b1;
                            acc       <= '0;
                            tap_cnt   <= '0;
                            win_cnt   <= win_cnt - 16'd1;
                        end else begin
                            acc     <= window_sum;
                            tap_cnt <= tap_cnt + 1'b1;
                        end
                    end
                end
                HOLD: begin
                    if (out_fire) begin
                        out_valid <= 1'b0;
                        if (win_cnt == 16'd0) begin
                            done <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_mac_accum.sv
// Self-checking bench for conv_mac_accum: two instances (ReLU on / off) share one
// stimulus stream; window sums are predicted with plain integer arithmetic.
module tb_conv_mac_accum;

    localparam int KSIZE = 9;
    localparam int ACC_W = 20;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [15:0]      n_windows;
    logic             in_valid;
    logic [7:0]       pixel;
    logic [7:0]       weight;
    logic             out_ready;

    logic             in_ready_r, out_valid_r, busy_r, done_r;
    logic [ACC_W-1:0] out_data_r;
    logic             in_ready_n, out_valid_n, busy_n, done_n;
    logic [ACC_W-1:0] out_data_n;

    int errors = 0;
    int checks = 0;
    int done_pulses = 0;

    logic [7:0] cur_pix [KSIZE];
    logic [7:0] cur_wt  [KSIZE];

    conv_mac_accum #(.KSIZE(KSIZE), .ACC_W(ACC_W), .RELU(1'b1)) dut_relu (
        .clk(clk), .rst(rst), .start(start), .n_windows(n_windows),
        .in_valid(in_valid), .in_ready(in_ready_r), .pixel(pixel), .weight(weight),
        .out_valid(out_valid_r), .out_ready(out_ready), .out_data(out_data_r),
        .busy(busy_r), .done(done_r)
    );

    conv_mac_accum #(.KSIZE(KSIZE), .ACC_W(ACC_W), .RELU(1'b0)) dut_raw (
        .clk(clk), .rst(rst), .start(start), .n_windows(n_windows),
        .in_valid(in_valid), .in_ready(in_ready_n), .pixel(pixel), .weight(weight),
        .out_valid(out_valid_n), .out_ready(out_ready), .out_data(out_data_n),
        .busy(busy_n), .done(done_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (done_r) done_pulses++;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    // Reference: the window result is the plain signed dot product of the current tap arrays.
    function automatic int model_sum();
        int s = 0;
        for (int i = 0; i < KSIZE; i++) s += int'(cur_pix[i]) * int'($signed(cur_wt[i]));
        return s;
    endfunction

    function automatic logic [ACC_W-1:0] model_raw(input int s);
        return ACC_W'(s);
    endfunction

    function automatic logic [ACC_W-1:0] model_relu(input int s);
        return (s < 0) ? '0 : ACC_W'(s);
    endfunction

    task automatic randomize_window();
        for (int i = 0; i < KSIZE; i++) begin
            cur_pix[i] = 8'($urandom);
            cur_wt[i]  = 8'($urandom);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; n_windows = '0; in_valid = 1'b0;
        pixel = '0; weight = '0; out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic start_job(input logic [15:0] n);
        start = 1'b1;
        n_windows = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Presents the KSIZE taps of cur_pix/cur_wt, optionally with random idle gaps.
    task automatic feed_window(input bit gaps, output bit early, output bit lat_ok, output bit timeout);
        int tap = 0;
        int guard = 0;
        early = 1'b0; lat_ok = 1'b0; timeout = 1'b0;
        while (tap < KSIZE && !timeout) begin
            if (gaps && ($urandom_range(0, 1) == 0)) begin
                in_valid = 1'b0; pixel = 8'($urandom); weight = 8'($urandom);
            end else if (in_ready_r) begin
                in_valid = 1'b1; pixel = cur_pix[tap]; weight = cur_wt[tap];
                tap++;
            end else begin
                in_valid = 1'b0;
            end
            if (out_valid_r || out_valid_n) early = 1'b1;
            @(negedge clk);
            guard++;
            if (guard > 200) timeout = 1'b1;
        end
        in_valid = 1'b0;
        lat_ok = out_valid_r && out_valid_n;
    endtask

    task automatic take_result(input int hold, output logic [ACC_W-1:0] d_r, output logic [ACC_W-1:0] d_n,
                               output int bad, output bit got_done, output bit dropped, output bit timeout);
        int guard = 0;
        bad = 0; got_done = 1'b0; dropped = 1'b0; timeout = 1'b0; d_r = '0; d_n = '0;
        while (!out_valid_r && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!out_valid_r) begin
            timeout = 1'b1;
        end else begin
            d_r = out_data_r;
            d_n = out_data_n;
            out_ready = 1'b0;
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                if (in_ready_r || in_ready_n || !out_valid_r || (out_data_r !== d_r) || (out_data_n !== d_n)) bad++;
            end
            out_ready = 1'b1;
            @(negedge clk);
            out_ready = 1'b0;
            got_done = done_r;
            dropped = !out_valid_r && !out_valid_n;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; n_windows = '0; in_valid = 1'b0;
        pixel = '0; weight = '0; out_ready = 1'b0;
        #1;
        checks++;
        if ({out_valid_r, out_valid_n, in_ready_r, in_ready_n, busy_r, busy_n, done_r, done_n} !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: got %b expected 00000000",
                     {out_valid_r, out_valid_n, in_ready_r, in_ready_n, busy_r, busy_n, done_r, done_n});
        end
        checks++;
        if (out_data_r !== '0 || out_data_n !== '0) begin
            errors++;
            $display("[TB] FAIL reset_data: got %h/%h expected 0", out_data_r, out_data_n);
        end
        do_reset();
        checks++;
        if (busy_r !== 1'b0 || in_ready_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: busy=%b in_ready=%b expected 0/0", busy_r, in_ready_r);
        end
    endtask

    task automatic test_ramp();
        logic [ACC_W-1:0] d_r, d_n;
        int bad; bit early, lat_ok, tmo, got_done, dropped;
        for (int i = 0; i < KSIZE; i++) begin
            cur_pix[i] = 8'(i + 1);
            cur_wt[i]  = 8'd1;
        end
        start_job(16'd1);
        checks++;
        if (busy_r !== 1'b1 || in_ready_r !== 1'b1) begin
            errors++;
            $display("[TB] FAIL ramp_busy: busy=%b in_ready=%b expected 1/1", busy_r, in_ready_r);
        end
        feed_window(1'b0, early, lat_ok, tmo);
        checks++;
        if (tmo || early || !lat_ok) begin
            errors++;
            $display("[TB] FAIL ramp_latency: timeout=%b early=%b valid_next=%b expected 0/0/1", tmo, early, lat_ok);
        end
        take_result(0, d_r, d_n, bad, got_done, dropped, tmo);
        checks++;
        if (d_r !== 20'd45 || d_n !== 20'd45) begin
            errors++;
            $display("[TB] FAIL ramp_sum: got %0d/%0d expected 45", d_r, d_n);
        end
        checks++;
        if (tmo || !got_done || !dropped) begin
            errors++;
            $display("[TB] FAIL ramp_done: timeout=%b done=%b valid_dropped=%b expected 0/1/1", tmo, got_done, dropped);
        end
        @(negedge clk);
        checks++;
        if (done_r !== 1'b0 || busy_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ramp_idle: done=%b busy=%b expected 0/0", done_r, busy_r);
        end
    endtask

    task automatic run_fixed(input logic [7:0] pv, input logic [7:0] wv, input string name);
        logic [ACC_W-1:0] d_r, d_n;
        int bad, s; bit early, lat_ok, tmo, got_done, dropped;
        for (int i = 0; i < KSIZE; i++) begin
            cur_pix[i] = pv;
            cur_wt[i]  = wv;
        end
        s = model_sum();
        start_job(16'd1);
        feed_window(1'b0, early, lat_ok, tmo);
        take_result(2, d_r, d_n, bad, got_done, dropped, tmo);
        checks++;
        if (tmo || d_r !== model_relu(s)) begin
            errors++;
            $display("[TB] FAIL %s_relu: got %h expected %h", name, d_r, model_relu(s));
        end
        checks++;
        if (tmo || d_n !== model_raw(s)) begin
            errors++;
            $display("[TB] FAIL %s_raw: got %h expected %h", name, d_n, model_raw(s));
        end
        @(negedge clk);
    endtask

    task automatic test_relu();
        run_fixed(8'd10, 8'hFF, "neg_ones");
        checks++;
        if (out_data_n !== 20'hFFFA6 || out_data_r !== 20'h00000) begin
            errors++;
            $display("[TB] FAIL neg_ones_const: got %h/%h expected 00000/FFFA6", out_data_r, out_data_n);
        end
    endtask

    task automatic test_extremes();
        run_fixed(8'd255, 8'h80, "min_weight");
        checks++;
        if ($signed(out_data_n) !== -20'sd293760) begin
            errors++;
            $display("[TB] FAIL min_weight_const: got %0d expected -293760", $signed(out_data_n));
        end
        run_fixed(8'd255, 8'd127, "max_weight");
        checks++;
        if (out_data_n !== 20'd291465 || out_data_r !== 20'd291465) begin
            errors++;
            $display("[TB] FAIL max_weight_const: got %0d/%0d expected 291465", out_data_r, out_data_n);
        end
    endtask

    task automatic test_backpressure();
        logic [ACC_W-1:0] d_r, d_n;
        int bad, s, pulses0; bit early, lat_ok, tmo, got_done, dropped;
        pulses0 = done_pulses;
        start_job(16'd3);
        for (int w = 0; w < 3; w++) begin
            randomize_window();
            s = model_sum();
            feed_window(1'b0, early, lat_ok, tmo);
            start = 1'b1;
            n_windows = 16'd7;
            @(negedge clk);
            start = 1'b0;
            take_result(5, d_r, d_n, bad, got_done, dropped, tmo);
            checks++;
            if (tmo || d_r !== model_relu(s) || d_n !== model_raw(s)) begin
                errors++;
                $display("[TB] FAIL bp_window%0d: got %h/%h expected %h/%h", w, d_r, d_n, model_relu(s), model_raw(s));
            end
            checks++;
            if (bad != 0) begin
                errors++;
                $display("[TB] FAIL bp_hold%0d: unstable_cycles=%0d expected 0", w, bad);
            end
            checks++;
            if (got_done !== (w == 2)) begin
                errors++;
                $display("[TB] FAIL bp_done%0d: got %b expected %b", w, got_done, (w == 2));
            end
        end
        repeat (3) @(negedge clk);
        checks++;
        if (done_pulses - pulses0 != 1 || busy_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL bp_single_done: pulses=%0d busy=%b expected 1/0", done_pulses - pulses0, busy_r);
        end
    endtask

    task automatic test_gaps();
        logic [ACC_W-1:0] d_r, d_n;
        int bad, s; bit early, lat_ok, tmo, got_done, dropped;
        start_job(16'd2);
        for (int w = 0; w < 2; w++) begin
            randomize_window();
            s = model_sum();
            feed_window(1'b1, early, lat_ok, tmo);
            checks++;
            if (tmo || early || !lat_ok) begin
                errors++;
                $display("[TB] FAIL gaps_taps%0d: timeout=%b early=%b valid_next=%b expected 0/0/1", w, tmo, early, lat_ok);
            end
            take_result($urandom_range(0, 3), d_r, d_n, bad, got_done, dropped, tmo);
            checks++;
            if (tmo || d_r !== model_relu(s) || d_n !== model_raw(s)) begin
                errors++;
                $display("[TB] FAIL gaps_sum%0d: got %h/%h expected %h/%h", w, d_r, d_n, model_relu(s), model_raw(s));
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midjob();
        logic [ACC_W-1:0] d_r, d_n;
        int bad, s, pulses0; bit early, lat_ok, tmo, got_done, dropped;
        pulses0 = done_pulses;
        start_job(16'd2);
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; pixel = 8'($urandom); weight = 8'($urandom);
            @(negedge clk);
        end
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({out_valid_r, in_ready_r, busy_r, done_r} !== 4'b0000 || out_data_r !== '0 || out_data_n !== '0) begin
            errors++;
            $display("[TB] FAIL midjob_reset: ctrl=%b data=%h/%h expected 0000/0/0",
                     {out_valid_r, in_ready_r, busy_r, done_r}, out_data_r, out_data_n);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (done_pulses != pulses0) begin
            errors++;
            $display("[TB] FAIL midjob_no_done: pulses=%0d expected 0", done_pulses - pulses0);
        end
        randomize_window();
        s = model_sum();
        start_job(16'd1);
        feed_window(1'b0, early, lat_ok, tmo);
        take_result(1, d_r, d_n, bad, got_done, dropped, tmo);
        checks++;
        if (tmo || d_r !== model_relu(s) || d_n !== model_raw(s) || !got_done) begin
            errors++;
            $display("[TB] FAIL post_reset_sum: got %h/%h done=%b expected %h/%h done=1",
                     d_r, d_n, got_done, model_relu(s), model_raw(s));
        end
        @(negedge clk);
        start_job(16'd0);
        checks++;
        if (done_r !== 1'b1 || out_valid_r !== 1'b0 || busy_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_job: done=%b out_valid=%b busy=%b expected 1/0/0", done_r, out_valid_r, busy_r);
        end
        @(negedge clk);
        checks++;
        if (done_r !== 1'b0 || out_valid_r !== 1'b0) begin
            errors++;
            $display("[TB] FAIL zero_job_pulse: done=%b out_valid=%b expected 0/0", done_r, out_valid_r);
        end
    endtask

    initial begin
        test_reset();
        test_ramp();
        test_relu();
        test_extremes();
        test_backpressure();
        test_gaps();
        test_reset_midjob();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
